// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Brief    : Shared types, register offsets and bit indices for uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam logic [3:0] c_rxdata_off = 4'h0;
    localparam logic [3:0] c_status_off = 4'h4;
    localparam logic [3:0] c_ctrl_off   = 4'h8;

    localparam int c_st_nempty_bit = 0;
    localparam int c_st_full_bit   = 1;
    localparam int c_st_ovr_bit    = 2;
    localparam int c_st_ferr_bit   = 3;
    localparam int c_st_busy_bit   = 4;

    localparam int c_ctrl_en_bit    = 0;
    localparam int c_ctrl_ie_bit    = 1;
    localparam int c_ctrl_clr_bit   = 2;
    localparam int c_ctrl_flush_bit = 3;

    // STATUS shows the FIFO count in a 4-bit field, clamped at 15.
    function automatic logic [3:0] sat_count(input logic [6:0] v);
        return (v > 7'd15) ? 4'hF : v[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Synchronous byte FIFO with push, pop and flush (flush dominates).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [7:0]               o_head
);
    localparam int c_aw = $clog2(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Memory-mapped 8N1 UART receiver with receive FIFO and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        uart_rx_valid,
    input  logic        rx,
    output logic        rx_interrupt
);
    localparam int          c_aw   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] c_half = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_full = 16'(CLKS_PER_BIT - 1);

    logic            r_rx_meta, r_rx_s, r_rx_prev;
    rx_state_e       r_state, w_state_next;
    logic [15:0]     r_cnt, w_cnt_next;
    logic [2:0]      r_bit_idx, w_bit_idx_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            w_stop_ok, w_stop_bad;
    logic            r_push;
    logic            r_en, r_ie, r_ovr, r_ferr, r_irq, r_rd_prev;
    logic            w_hit, w_rd_rxdata, w_rd_status, w_rd_ctrl, w_wr_ctrl;
    logic            w_flush, w_clr, w_pop;
    logic            w_full, w_empty;
    logic [c_aw:0]   w_count;
    logic [7:0]      w_head;
    logic            w_unused_bits;

    assign w_unused_bits = &{1'b0, write_data[31:4]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_push    <= w_stop_ok;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok      = 1'b0;
        w_stop_bad     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s && r_rx_prev) begin
                    w_cnt_next   = c_half;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    if (r_rx_s) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next     = c_full;
                        w_bit_idx_next = '0;
                        w_state_next   = ST_DATA;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    // Line order is LSB first, so bits enter at the top.
                    w_shift_next   = {r_rx_s, r_shift[7:1]};
                    w_cnt_next     = c_full;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (r_cnt == '0) begin
                    w_stop_ok    = r_rx_s;
                    w_stop_bad   = !r_rx_s;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (!r_en) begin
            w_state_next = ST_IDLE;
            w_stop_ok    = 1'b0;
            w_stop_bad   = 1'b0;
        end
    end

    assign w_hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign w_rd_rxdata   = read_enable && w_hit && (addr[3:0] == c_rxdata_off);
    assign w_rd_status   = read_enable && w_hit && (addr[3:0] == c_status_off);
    assign w_rd_ctrl     = read_enable && w_hit && (addr[3:0] == c_ctrl_off);
    assign w_wr_ctrl     = write_enable && w_hit && (addr[3:0] == c_ctrl_off);
    assign w_flush       = w_wr_ctrl && write_data[c_ctrl_flush_bit];
    assign w_clr         = w_wr_ctrl && write_data[c_ctrl_clr_bit];
    // Only the first cycle of a (possibly stalled) RXDATA load pops.
    assign w_pop         = w_rd_rxdata && !r_rd_prev && !w_empty;
    assign uart_rx_valid = w_rd_rxdata || w_rd_status || w_rd_ctrl;
    assign rx_interrupt  = r_irq;

    always_comb begin
        read_data = '0;
        if (w_rd_rxdata && !w_empty) begin
            read_data = {23'd0, 1'b1, w_head};
        end else if (w_rd_status) begin
            read_data = {20'd0, sat_count(7'(w_count)), 3'd0,
                         (r_state != ST_IDLE), r_ferr, r_ovr, w_full, !w_empty};
        end else if (w_rd_ctrl) begin
            read_data = {30'd0, r_ie, r_en};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_ovr     <= 1'b0;
            r_ferr    <= 1'b0;
            r_irq     <= 1'b0;
            r_rd_prev <= 1'b0;
        end else begin
            r_rd_prev <= w_rd_rxdata;
            if (w_wr_ctrl) begin
                r_en <= write_data[c_ctrl_en_bit];
                r_ie <= write_data[c_ctrl_ie_bit];
            end
            if (w_clr) begin
                r_ovr  <= 1'b0;
                r_ferr <= 1'b0;
            end
            if (w_stop_bad)                    r_ferr <= 1'b1;
            if (r_push && w_full && !w_flush)  r_ovr  <= 1'b1;
            r_irq <= r_ie && (!w_empty || r_ovr || r_ferr);
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_push),
        .i_push_data (r_shift),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (16 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int          c_cpb  = 16;
    localparam logic [31:0] c_base = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        uart_rx_valid;
    logic        rx = 1'b1;
    logic        rx_interrupt;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx #(
        .CLKS_PER_BIT (c_cpb),
        .FIFO_DEPTH   (8),
        .BASE_ADDR    (c_base)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .read_data     (read_data),
        .uart_rx_valid (uart_rx_valid),
        .rx            (rx),
        .rx_interrupt  (rx_interrupt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (c_cpb) tick();
    endtask

    task automatic send_head(input logic [7:0] d);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_head(d);
        bit_time(1'b1);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr         = c_base | {28'd0, off};
        write_data   = d;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        write_data   = '0;
    endtask

    task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        addr        = c_base | {28'd0, off};
        read_enable = 1'b1;
        #1;
        chk(tag, read_data, exp);
        tick();
        read_enable = 1'b0;
        tick();
    endtask

    // Leaves a STATUS read active so the caller can inspect the exact cycle.
    task automatic poll_status(input string tag, input int b, input logic v, input int budget);
        int k;
        addr        = c_base | 32'h4;
        read_enable = 1'b1;
        #1;
        k = 0;
        while (read_data[b] !== v && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, read_data[b]}, {31'd0, v});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_irq", {31'd0, rx_interrupt}, 32'd0);
        chk("rst_valid", {31'd0, uart_rx_valid}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        rst = 1'b1;
        tick();
        rd("rst_status", 4'h4, 32'h0);
        rd("rst_ctrl", 4'h8, 32'h0);

        wr(4'h8, 32'h1);
        rd("ctrl_en", 4'h8, 32'h1);

        // Basic frame
        send_byte(8'hA5);
        tick();
        tick();
        rd("a5_status", 4'h4, 32'h101);
        chk("a5_irq", {31'd0, rx_interrupt}, 32'd0);
        rd("a5_rxdata", 4'h0, 32'h1A5);
        rd("a5_status_after", 4'h4, 32'h0);

        // Address decode
        read_enable = 1'b1;
        addr = c_base | 32'hC;
        #1;
        chk("undef_valid", {31'd0, uart_rx_valid}, 32'd0);
        chk("undef_rdata", read_data, 32'd0);
        addr = c_base + 32'h14;
        #1;
        chk("miss_valid", {31'd0, uart_rx_valid}, 32'd0);
        addr = c_base | 32'h4;
        #1;
        chk("hit_valid", {31'd0, uart_rx_valid}, 32'd1);
        read_enable = 1'b0;
        tick();

        // Glitch: 5 low cycles
        rx = 1'b0;
        repeat (4) tick();
        addr = c_base | 32'h4;
        read_enable = 1'b1;
        #1;
        chk("glitch_busy", {31'd0, read_data[4]}, 32'd1);
        tick();
        rx = 1'b1;
        poll_status("glitch_idle", 4, 1'b0, 10);
        chk("glitch_status", read_data, 32'h0);
        read_enable = 1'b0;
        tick();

        // Framing error with interrupt enabled
        wr(4'h8, 32'h3);
        send_head(8'h3C);
        rx = 1'b0;
        poll_status("ferr_set", 3, 1'b1, 40);
        chk("ferr_irq_lag", {31'd0, rx_interrupt}, 32'd0);
        tick();
        chk("ferr_irq", {31'd0, rx_interrupt}, 32'd1);
        chk("ferr_status", read_data, 32'h008);
        read_enable = 1'b0;
        repeat (10) tick();
        rx = 1'b1;
        repeat (20) tick();
        wr(4'h8, 32'h6);
        rd("ferr_clear", 4'h4, 32'h0);
        chk("ferr_irq_drop", {31'd0, rx_interrupt}, 32'd0);
        rd("ctrl_w1c", 4'h8, 32'h2);

        // Overrun: nine bytes into an eight-deep FIFO
        wr(4'h8, 32'h1);
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        tick();
        rd("ovr_status", 4'h4, 32'h807);
        for (int i = 0; i < 8; i++) rd($sformatf("ovr_rx%0d", i), 4'h0, 32'h100 | i);
        rd("ovr_rx_empty", 4'h0, 32'h0);
        wr(4'h8, 32'h5);
        rd("ovr_clear", 4'h4, 32'h0);

        // Stalled load pops once
        send_byte(8'h11);
        send_byte(8'h22);
        tick();
        addr = c_base;
        read_enable = 1'b1;
        #1;
        chk("stall_head", read_data, 32'h111);
        repeat (3) tick();
        read_enable = 1'b0;
        tick();
        rd("stall_status", 4'h4, 32'h101);
        rd("stall_next", 4'h0, 32'h122);

        // Reset in the middle of data bit 4
        wr(4'h8, 32'h3);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'(8'h5A >> i));
        rx = 1'b1;
        repeat (8) tick();
        addr = c_base | 32'h4;
        read_enable = 1'b1;
        #1;
        chk("mid_busy", {31'd0, read_data[4]}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_status", read_data, 32'h0);
        read_enable = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, uart_rx_valid}, 32'd0);
        chk("mid_rst_irq", {31'd0, rx_interrupt}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (20) tick();
        rd("mid_rst_ctrl", 4'h8, 32'h0);
        rd("mid_rst_idle", 4'h4, 32'h0);
        wr(4'h8, 32'h1);
        send_byte(8'h5A);
        tick();
        rd("rx_5a", 4'h0, 32'h15A);
        rd("rx_5a_status", 4'h4, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
